// File: rtl/corr_frame_transmitter.sv
// corr_frame_transmitter: forwards only the first corr_len = min(N1+N2-1, NFFT)
// lags of each NFFT-sample IFFT frame and drops the zero-padded tail.
// A 2-entry skid buffer gives 1 beat/cycle with a registered s_tready.
module corr_frame_transmitter #(
  parameter int NFFT  = 1024,
  parameter int LEN_W = 16
) (
  input  logic             aclk,
  input  logic             aresetn,
  input  logic [LEN_W-1:0] N1,
  input  logic [LEN_W-1:0] N2,
  input  logic [31:0]      s_tdata,
  input  logic             s_tvalid,
  output logic             s_tready,
  input  logic             s_tlast,
  output logic [31:0]      m_tdata,
  output logic             m_tvalid,
  input  logic             m_tready,
  output logic             m_tlast,
  output logic             idle,
  output logic             frame_err
);

  localparam int CNT_W = $clog2(NFFT);
  localparam int CL_W  = (LEN_W + 1 > CNT_W + 1) ? LEN_W + 1 : CNT_W + 1;
  localparam logic [CL_W-1:0]  NFFT_L   = CL_W'(NFFT);
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NFFT - 1);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_PASS = 2'd1;
  localparam logic [1:0] ST_DROP = 2'd2;

  // Kept-lag count; a zero-length input still yields the single zero lag.
  function automatic logic [CL_W-1:0] calc_len(input logic [LEN_W-1:0] a,
                                               input logic [LEN_W-1:0] b);
    logic [CL_W-1:0] sum;
    sum = CL_W'(a) + CL_W'(b);
    if (a == '0 || b == '0) return CL_W'(1);
    else if (sum - CL_W'(1) > NFFT_L) return NFFT_L;
    else return sum - CL_W'(1);
  endfunction

  logic [1:0]       state, state_next;
  logic [CNT_W-1:0] in_cnt;
  logic [CL_W-1:0]  corr_len, len_new, len_eff;
  logic [1:0]       count, count_next;
  logic [32:0]      ent0, ent1, din;
  logic             acc, keep, push, pop, last_lag, at_end, frame_done, bad;

  assign acc        = s_tvalid && s_tready;
  assign len_new    = calc_len(N1, N2);
  assign len_eff    = (state == ST_IDLE) ? len_new : corr_len;
  assign last_lag   = (CL_W'(in_cnt) == len_eff - CL_W'(1));
  assign at_end     = (in_cnt == LAST_IDX);
  assign frame_done = at_end || s_tlast;
  assign bad        = (s_tlast != at_end);
  assign keep       = (state != ST_DROP);
  assign push       = acc && keep;
  assign pop        = m_tvalid && m_tready;
  assign din        = {last_lag || s_tlast, s_tdata};

  assign m_tvalid = (count != 2'd0);
  assign m_tdata  = ent0[31:0];
  assign m_tlast  = ent0[32];
  assign idle     = (state == ST_IDLE) && (count == 2'd0);

  // Next FSM state and buffer occupancy for this cycle's handshakes.
  always_comb begin
    state_next = state;
    count_next = count + {1'b0, push} - {1'b0, pop};
    if (acc) begin
      if (frame_done)                 state_next = ST_IDLE;
      else if (keep && last_lag)      state_next = ST_DROP;
      else if (state == ST_IDLE)      state_next = ST_PASS;
    end
  end

  // Control registers: FSM, frame counter, latched length, ready, error pulse.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state     <= ST_IDLE;
      in_cnt    <= '0;
      corr_len  <= CL_W'(1);
      count     <= 2'd0;
      s_tready  <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      state     <= state_next;
      count     <= count_next;
      s_tready  <= (state_next == ST_DROP) || (count_next != 2'd2);
      frame_err <= acc && bad;
      if (acc) in_cnt <= frame_done ? '0 : in_cnt + CNT_W'(1);
      if (acc && state == ST_IDLE) corr_len <= len_new;
    end
  end

  // Head entry drives the output and is cleared so no beat survives reset.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      ent0 <= '0;
    end else begin
      unique case (count)
        2'd0:    if (push) ent0 <= din;
        2'd1:    if (push && pop) ent0 <= din;
        default: if (pop) ent0 <= ent1;
      endcase
    end
  end

  // Spare entry only holds data while the head is stalled; never observed after reset.
  always_ff @(posedge aclk) begin
    if (count == 2'd1 && push && !pop) ent1 <= din;
    else if (count == 2'd2 && push && pop) ent1 <= din;
  end

endmodule

// File: tb/tb_corr_frame_transmitter.sv
// Directed bench for corr_frame_transmitter with NFFT=16.
module tb_corr_frame_transmitter;

  logic        aclk = 1'b0;
  logic        aresetn;
  logic [15:0] N1, N2;
  logic [31:0] s_tdata;
  logic        s_tvalid, s_tready, s_tlast;
  logic [31:0] m_tdata;
  logic        m_tvalid, m_tready, m_tlast;
  logic        idle, frame_err;

  int errors = 0;
  int checks = 0;
  int err_seen = 0;
  int mode = 0;
  logic [32:0] q[$];

  corr_frame_transmitter #(.NFFT(16), .LEN_W(16)) dut (
    .aclk(aclk), .aresetn(aresetn), .N1(N1), .N2(N2),
    .s_tdata(s_tdata), .s_tvalid(s_tvalid), .s_tready(s_tready), .s_tlast(s_tlast),
    .m_tdata(m_tdata), .m_tvalid(m_tvalid), .m_tready(m_tready), .m_tlast(m_tlast),
    .idle(idle), .frame_err(frame_err)
  );

  always #5 aclk = ~aclk;

  // m_tready: always high in mode 0, pattern 1,0,0,1 in mode 1
  initial begin
    int phase;
    phase = 0;
    m_tready = 1'b1;
    forever begin
      @(posedge aclk);
      #1;
      m_tready = (mode == 0) ? 1'b1 : ((phase == 0 || phase == 3) ? 1'b1 : 1'b0);
      phase = (phase + 1) % 4;
    end
  end

  // Output monitor: collects transfers, checks hold during stalls, counts error pulses
  initial begin
    logic        stalled;
    logic [31:0] held_d;
    logic        held_l;
    stalled = 1'b0;
    held_d = '0;
    held_l = 1'b0;
    forever begin
      @(negedge aclk);
      if (aresetn !== 1'b1) begin
        stalled = 1'b0;
      end else begin
        if (stalled) begin
          checks++;
          assert (m_tvalid === 1'b1 && m_tdata === held_d && m_tlast === held_l) else begin
            errors++;
            $error("FAIL stall_hold observed v=%0b d=%h l=%0b expected v=1 d=%h l=%0b",
                   m_tvalid, m_tdata, m_tlast, held_d, held_l);
          end
        end
        if (m_tvalid === 1'b1 && m_tready === 1'b1) q.push_back({m_tlast, m_tdata});
        stalled = (m_tvalid === 1'b1 && m_tready === 1'b0);
        held_d = m_tdata;
        held_l = m_tlast;
        if (frame_err === 1'b1) err_seen++;
      end
    end
  end

  task automatic drive_frame(input int nb, input int tl, input logic [15:0] tag,
                             input logic [15:0] a1, input logic [15:0] a2, input int chg,
                             input logic [15:0] b1, input logic [15:0] b2,
                             output int st_hi, output int st_all);
    int guard;
    bit tmo;
    tmo = 1'b0;
    st_hi = 0;
    st_all = 0;
    N1 = a1;
    N2 = a2;
    for (int k = 0; k < nb; k++) begin
      s_tvalid = 1'b1;
      s_tdata  = {tag, 16'(k)};
      s_tlast  = (k == tl);
      guard = 0;
      while (s_tready !== 1'b1 && guard < 64) begin
        @(posedge aclk);
        #1;
        guard++;
        st_all++;
        if (k >= 8) st_hi++;
      end
      if (guard >= 64) tmo = 1'b1;
      @(posedge aclk);
      #1;
      if (k == chg) begin
        N1 = b1;
        N2 = b2;
      end
    end
    s_tvalid = 1'b0;
    s_tlast  = 1'b0;
    checks++;
    assert (tmo == 1'b0) else begin
      errors++;
      $error("FAIL input_timeout tag=%0d observed stuck expected accept", tag);
    end
  endtask

  task automatic wait_idle(input string name);
    int guard;
    guard = 0;
    while (idle !== 1'b1 && guard < 100) begin
      @(posedge aclk);
      #1;
      guard++;
    end
    repeat (2) @(posedge aclk);
    #1;
    checks++;
    assert (idle === 1'b1) else begin
      errors++;
      $error("FAIL %s_idle observed %0b expected 1", name, idle);
    end
  endtask

  task automatic check_frame(input string name, input int n, input logic [15:0] tag);
    logic [32:0] got, exp;
    for (int i = 0; i < n; i++) begin
      exp = {(i == n - 1) ? 1'b1 : 1'b0, tag, 16'(i)};
      if (q.size() > 0) got = q.pop_front();
      else got = 'x;
      checks++;
      assert (got === exp) else begin
        errors++;
        $error("FAIL %s_beat%0d observed %h expected %h", name, i, got, exp);
      end
    end
  endtask

  task automatic check_int(input string name, input int got, input int exp);
    checks++;
    assert (got == exp) else begin
      errors++;
      $error("FAIL %s observed %0d expected %0d", name, got, exp);
    end
  endtask

  initial begin
    int sh, sa, e0;
    aresetn  = 1'b0;
    N1       = 16'd5;
    N2       = 16'd4;
    s_tdata  = '0;
    s_tvalid = 1'b0;
    s_tlast  = 1'b0;

    // Reset state
    #12;
    checks++;
    assert (m_tvalid === 1'b0 && m_tlast === 1'b0 && m_tdata === 32'h0 &&
            s_tready === 1'b0 && idle === 1'b1 && frame_err === 1'b0) else begin
      errors++;
      $error("FAIL reset_state observed v=%0b l=%0b d=%h r=%0b i=%0b e=%0b expected 0,0,0,0,1,0",
             m_tvalid, m_tlast, m_tdata, s_tready, idle, frame_err);
    end
    @(posedge aclk);
    #1;
    aresetn = 1'b1;
    check_int("ready_before_edge", int'(s_tready), 0);
    @(posedge aclk);
    #1;
    check_int("ready_after_edge", int'(s_tready), 1);

    // Basic frame: corr_len = 8
    e0 = err_seen;
    drive_frame(16, 15, 16'd1, 16'd5, 16'd4, -1, 16'd0, 16'd0, sh, sa);
    wait_idle("basic");
    check_int("basic_count", q.size(), 8);
    check_frame("basic", 8, 16'd1);
    check_int("basic_drop_stalls", sh, 0);
    check_int("basic_err", err_seen - e0, 0);

    // Backpressure 1,0,0,1
    mode = 1;
    drive_frame(16, 15, 16'd2, 16'd5, 16'd4, -1, 16'd0, 16'd0, sh, sa);
    wait_idle("bp");
    mode = 0;
    check_int("bp_count", q.size(), 8);
    check_frame("bp", 8, 16'd2);
    checks++;
    assert (sa > 0) else begin
      errors++;
      $error("FAIL bp_ready_drop observed %0d stalls expected >0", sa);
    end

    // Clamped length: 10+10-1 -> 16
    drive_frame(16, 15, 16'd3, 16'd10, 16'd10, -1, 16'd0, 16'd0, sh, sa);
    wait_idle("clamp");
    check_int("clamp_count", q.size(), 16);
    check_frame("clamp", 16, 16'd3);

    // Minimal length 1+1-1 = 1
    drive_frame(16, 15, 16'd4, 16'd1, 16'd1, -1, 16'd0, 16'd0, sh, sa);
    wait_idle("min");
    check_int("min_count", q.size(), 1);
    check_frame("min", 1, 16'd4);

    // Early tlast on kept beat 5
    e0 = err_seen;
    drive_frame(6, 5, 16'd5, 16'd5, 16'd4, -1, 16'd0, 16'd0, sh, sa);
    wait_idle("early");
    check_int("early_count", q.size(), 6);
    check_frame("early", 6, 16'd5);
    check_int("early_err", err_seen - e0, 1);

    // Missing tlast, then a normal frame must restart at k=0
    e0 = err_seen;
    drive_frame(16, -1, 16'd6, 16'd5, 16'd4, -1, 16'd0, 16'd0, sh, sa);
    wait_idle("miss");
    check_int("miss_err", err_seen - e0, 1);
    check_frame("miss", 8, 16'd6);

    // Three back-to-back frames, lengths changed mid frame 1
    e0 = err_seen;
    drive_frame(16, 15, 16'd7, 16'd5, 16'd4, 2, 16'd3, 16'd3, sh, sa);
    drive_frame(16, 15, 16'd8, 16'd3, 16'd3, -1, 16'd0, 16'd0, sh, sa);
    drive_frame(16, 15, 16'd9, 16'd2, 16'd2, -1, 16'd0, 16'd0, sh, sa);
    wait_idle("b2b");
    check_int("b2b_count", q.size(), 16);
    check_frame("b2b_f1", 8, 16'd7);
    check_frame("b2b_f2", 5, 16'd8);
    check_frame("b2b_f3", 3, 16'd9);
    check_int("b2b_err", err_seen - e0, 0);

    // Asynchronous reset mid-frame at in_cnt=3
    drive_frame(3, -1, 16'd10, 16'd5, 16'd4, -1, 16'd0, 16'd0, sh, sa);
    check_int("pre_reset_valid", int'(m_tvalid), 1);
    #1;
    aresetn = 1'b0;
    #1;
    checks++;
    assert (m_tvalid === 1'b0 && idle === 1'b1 && s_tready === 1'b0 && m_tdata === 32'h0) else begin
      errors++;
      $error("FAIL async_reset observed v=%0b i=%0b r=%0b d=%h expected 0,1,0,0",
             m_tvalid, idle, s_tready, m_tdata);
    end
    @(posedge aclk);
    #1;
    aresetn = 1'b1;
    @(posedge aclk);
    #1;
    q.delete();
    drive_frame(16, 15, 16'd11, 16'd5, 16'd4, -1, 16'd0, 16'd0, sh, sa);
    wait_idle("post_reset");
    check_int("post_reset_count", q.size(), 8);
    check_frame("post_reset", 8, 16'd11);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
